pakin_gen: RTL
==============

Name: pakin_gen

Overview:
- Packet source that drives a 4-phase req/ack link into a packet receiver, the transmit end of the channel that pakout_io drives.
- Generates addresses sweeping MIN_ADDR..MAX_ADDR, with an incrementing data field and an XOR redundancy field.
- Exposes sent-count and state through the standard debug channel for the board test top.

Parameters:
- PSZ, `NS_PACKET_SIZE: total packet width, must equal ASZ+DSZ+RSZ.
- ASZ, `NS_ADDRESS_SIZE: address field width.
- DSZ, `NS_DATA_SIZE: data field width.
- RSZ, `NS_REDUN_SIZE: redundancy field width. Constraint: RSZ <= ASZ and RSZ <= DSZ.
- MIN_ADDR, 1: first generated address.
- MAX_ADDR, 14: last generated address. Constraint: MIN_ADDR <= MAX_ADDR < 2^ASZ.

Ports:
- i_clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- src_en  in  1  pacing enable; a new packet starts only when src_en=1.
- ready  out  1  high once out of reset and IDLE has been reached.
- o0_req  out  1  link request.
- o0_ack  in  1  link acknowledge.
- o0_data  out  PSZ  packet: {addr[ASZ], data[DSZ], red[RSZ]}, addr in the MSBs.
- dbg_case  in  8  debug selector.
- dbg_doit  in  1  latch debug outputs.
- dbg_leds  out  4  debug LEDs.
- dbg_disp0  out  4  debug digit 0.
- dbg_disp1  out  4  debug digit 1.

Behaviour:
- Reset values:
  - o0_req=0, o0_data=0, ready=0, dbg_*=0.
  - addr_cnt=MIN_ADDR, data_cnt=0, sent_cnt(16b)=0.
  - State=RST.
- FSM:
  - RST -> IDLE in 1 cycle; ready=1 from IDLE onward, and it stays high until reset.
  - IDLE: if src_en and o0_ack=0:
    - load o0_data = {addr_cnt, data_cnt, red}, where red = addr_cnt[RSZ-1:0] ^ data_cnt[RSZ-1:0];
    - go to SET.
  - SET: raise o0_req (data already stable for ≥1 cycle) -> WAIT_ACK.
  - WAIT_ACK: on o0_ack=1:
    - drop o0_req;
    - sent_cnt+1, data_cnt+1 (wraps mod 2^DSZ);
    - addr_cnt+1, with MAX_ADDR -> MIN_ADDR wrap;
    - go to WAIT_NOACK.
  - WAIT_NOACK: on o0_ack=0 -> IDLE.
- Minimum packet period is 4 cycles with immediate ack.
- o0_data holds its value from load until the next load, so it is stable through the whole req/ack cycle.
- o0_ack high while in IDLE (peer still finishing) blocks a new packet; no error is flagged.
- src_en deasserted outside IDLE has no effect; the current handshake completes.
- Reset mid-handshake: o0_req=0 on the next cycle, all counters restart. The peer must tolerate req dropping before ack.
- sent_cnt wraps at 2^16.
- Debug: on the cycle after dbg_doit=1, dbg_* latch per dbg_case:
  - 0x00: leds=state code (RST=0, IDLE=1, SET=2, WAIT_ACK=3, WAIT_NOACK=4), disp0=addr_cnt[3:0], disp1=data_cnt[3:0].
  - 0x01: leds=0, disp0=sent_cnt[7:4], disp1=sent_cnt[3:0].
  - 0x02: leds={src_en,o0_ack,o0_req,ready}, disp0=sent_cnt[15:12], disp1=sent_cnt[11:8].
  - Other codes: all 0.
  - Debug outputs hold between dbg_doit pulses.

Optional Feature:
- Macro NS_PAKIN_ERR_INJECT_EN.
- When defined: every packet with sent_cnt[2:0]==3'b111 at load time has red[0] inverted. Addresses, data and the handshake are unchanged.
- When undefined: red is always correct.
- Ports are identical in both builds.

Test Plan:
- Reset, then src_en=1 with an auto-ack responder (ack one cycle after req) -> ready=1 at the 2nd cycle after reset release. First packet has addr=1, data=0, red=1. Second has addr=2, data=1, red=3.
- Send 15 packets -> addresses run 1..14, then the 15th is addr=1 (wrap). data_cnt=15 after the 15th ack.
- Hold o0_ack=0 for 20 cycles after req -> o0_req and o0_data stay stable; sent_cnt unchanged. Then ack pulse -> req drops the next cycle.
- o0_ack stuck high in IDLE with src_en=1 -> no new req. After ack falls, req rises within 2 cycles.
- Reset asserted in WAIT_ACK -> o0_req=0 next cycle. After release, the first packet is again addr=1, data=0.
- dbg_case=0x01 with dbg_doit after 10 packets -> disp0=0, disp1=10. With NS_PAKIN_ERR_INJECT_EN defined, the 8th packet (addr=8, data=7) has red=0xE instead of 0xF.

Source files
------------

// File: rtl/pakin_gen.sv
// Packet source for a 4-phase req/ack link: sweeps addresses MIN_ADDR..MAX_ADDR with incrementing data and XOR redundancy.
// Optional build macro NS_PAKIN_ERR_INJECT_EN corrupts red[0] on every packet loaded with sent_cnt[2:0]==3'b111.

`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 16
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakin_gen #(
  parameter int unsigned PSZ      = `NS_PACKET_SIZE,
  parameter int unsigned ASZ      = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ      = `NS_DATA_SIZE,
  parameter int unsigned RSZ      = `NS_REDUN_SIZE,
  parameter int unsigned MIN_ADDR = 1,
  parameter int unsigned MAX_ADDR = 14
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic           src_en,
  output logic           ready,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [PSZ-1:0] o0_data,
  input  logic [7:0]     dbg_case,
  input  logic           dbg_doit,
  output logic [3:0]     dbg_leds,
  output logic [3:0]     dbg_disp0,
  output logic [3:0]     dbg_disp1
);

  localparam int unsigned SCW = 16;

  typedef enum logic [2:0] {
    RST        = 3'd0,
    IDLE       = 3'd1,
    SET        = 3'd2,
    WAIT_ACK   = 3'd3,
    WAIT_NOACK = 3'd4
  } state_t;

  state_t         state;
  logic [ASZ-1:0] addr_cnt;
  logic [DSZ-1:0] data_cnt;
  logic [SCW-1:0] sent_cnt;
  logic [RSZ-1:0] red_c;

  // Redundancy field for the packet about to be loaded
  always_comb begin
    red_c = addr_cnt[RSZ-1:0] ^ data_cnt[RSZ-1:0];
`ifdef NS_PAKIN_ERR_INJECT_EN
    if (sent_cnt[2:0] == 3'b111) red_c[0] = ~red_c[0];
`endif
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state     <= RST;
      ready     <= 1'b0;
      o0_req    <= 1'b0;
      o0_data   <= '0;
      addr_cnt  <= ASZ'(MIN_ADDR);
      data_cnt  <= '0;
      sent_cnt  <= '0;
      dbg_leds  <= '0;
      dbg_disp0 <= '0;
      dbg_disp1 <= '0;
    end else begin
      case (state)
        RST: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        IDLE: begin
          // ack still high means the peer has not finished the previous cycle
          if (src_en && !o0_ack) begin
            o0_data <= {addr_cnt, data_cnt, red_c};
            state   <= SET;
          end
        end
        SET: begin
          o0_req <= 1'b1;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (o0_ack) begin
            o0_req   <= 1'b0;
            sent_cnt <= sent_cnt + SCW'(1);
            data_cnt <= data_cnt + DSZ'(1);
            addr_cnt <= (addr_cnt == ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : addr_cnt + ASZ'(1);
            state    <= WAIT_NOACK;
          end
        end
        WAIT_NOACK: begin
          if (!o0_ack) state <= IDLE;
        end
        default: state <= RST;
      endcase

      if (dbg_doit) begin
        case (dbg_case)
          8'h00: begin
            dbg_leds  <= 4'(state);
            dbg_disp0 <= addr_cnt[3:0];
            dbg_disp1 <= data_cnt[3:0];
          end
          8'h01: begin
            dbg_leds  <= 4'd0;
            dbg_disp0 <= sent_cnt[7:4];
            dbg_disp1 <= sent_cnt[3:0];
          end
          8'h02: begin
            dbg_leds  <= {src_en, o0_ack, o0_req, ready};
            dbg_disp0 <= sent_cnt[15:12];
            dbg_disp1 <= sent_cnt[11:8];
          end
          default: begin
            dbg_leds  <= 4'd0;
            dbg_disp0 <= 4'd0;
            dbg_disp1 <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
